// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline
// writeback and a small FIFO of buffered long-latency results.
module wb_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write_w,
  input  logic [4:0]            rd_w,
  input  logic [DATA_WIDTH-1:0] result_w,
  input  logic                  lu_valid,
  input  logic [4:0]            lu_rd,
  input  logic [DATA_WIDTH-1:0] lu_data,
  output logic                  lu_ready,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  stall_w,
  output logic [31:0]           pend_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    STARVE
  } state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [WW-1:0]         wait_cnt;
  logic [DEPTH-1:0]      vld;
  logic [4:0]            q_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] q_data [DEPTH];

  logic          pipe_req;
  logic          non_empty;
  logic          starve;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_nx;
  logic [WW-1:0] wait_nx;

  assign non_empty = (count != '0);
  assign starve    = (state == STARVE);
  assign pipe_req  = rst_n && reg_write_w && (rd_w != 5'd0);
  assign lu_ready  = (count != CW'(DEPTH));
  // x0 results are acknowledged but never buffered
  assign push      = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign pop       = starve || (non_empty && !pipe_req);
  assign stall_w   = starve;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (1'b1)
      pop: begin
        rf_we    = 1'b1;
        rf_waddr = q_rd[rd_ptr];
        rf_wdata = q_data[rd_ptr];
      end
      (pipe_req && !starve): begin
        rf_we    = 1'b1;
        rf_waddr = rd_w;
        rf_wdata = result_w;
      end
      default: ;
    endcase
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i]) pend_mask[q_rd[i]] = 1'b1;
  end

  assign count_nx = count + CW'(push) - CW'(pop);

  always_comb begin
    wait_nx = wait_cnt;
    if (pop || count_nx == '0)
      wait_nx = '0;
    else if (non_empty && wait_cnt != WW'(MAX_WAIT))
      wait_nx = wait_cnt + WW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      wait_cnt <= '0;
      vld      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (push) begin
        vld[wr_ptr]    <= 1'b1;
        q_rd[wr_ptr]   <= lu_rd;
        q_data[wr_ptr] <= lu_data;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      count    <= count_nx;
      wait_cnt <= wait_nx;
      if (count_nx == '0)
        state <= IDLE;
      else if (wait_nx == WW'(MAX_WAIT))
        state <= STARVE;
      else
        state <= PEND;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table driven through
// an expected-result queue, plus an asynchronous-reset sequence.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_w;
  logic [31:0] pend_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_WIDTH(32),
    .DEPTH(2),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .reg_write_w(reg_write_w),
    .rd_w(rd_w),
    .result_w(result_w),
    .lu_valid(lu_valid),
    .lu_rd(lu_rd),
    .lu_data(lu_data),
    .lu_ready(lu_ready),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .stall_w(stall_w),
    .pend_mask(pend_mask)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
    logic [31:0] e_mask;
    logic        e_rdy;
  } vec_t;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic [31:0] mask;
    logic        rdy;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t v(
    logic rst, logic we, logic [4:0] rd, logic [31:0] res,
    logic lv, logic [4:0] lrd, logic [31:0] ld,
    logic e_we, logic [4:0] e_addr, logic [31:0] e_data,
    logic e_stall, logic [31:0] e_mask, logic e_rdy);
    vec_t r;
    r = '{rst, we, rd, res, lv, lrd, ld,
          e_we, e_addr, e_data, e_stall, e_mask, e_rdy};
    return r;
  endfunction

  task automatic apply(input vec_t t, input string nm);
    exp_t e;
    rst_n       = t.rst;
    reg_write_w = t.we;
    rd_w        = t.rd;
    result_w    = t.res;
    lu_valid    = t.lv;
    lu_rd       = t.lrd;
    lu_data     = t.ld;
    e = '{nm, t.e_we, t.e_addr, t.e_data, t.e_stall, t.e_mask, t.e_rdy};
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty queue, nothing expected");
      return;
    end
    e = sb.pop_front();
    if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data ||
        stall_w !== e.stall || pend_mask !== e.mask ||
        lu_ready !== e.rdy) begin
      errors++;
      $display("FAIL %s: got we=%b addr=%0d data=%h stall=%b mask=%h rdy=%b, want we=%b addr=%0d data=%h stall=%b mask=%h rdy=%b",
               e.name, rf_we, rf_waddr, rf_wdata, stall_w, pend_mask,
               lu_ready, e.we, e.addr, e.data, e.stall, e.mask, e.rdy);
    end
  endtask

  task automatic step(input vec_t t, input string nm);
    apply(t, nm);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, then pipeline write in the same cycle
    tbl.push_back(v(0, 1, 5, 32'hA5, 0, 0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 1, 5, 32'hA5, 0, 0, 0,  1, 5, 32'hA5, 0, 0, 1));
    // idle-slot drain
    tbl.push_back(v(1, 0, 0, 0, 1, 7, 32'h1234,  0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  1, 7, 32'h1234, 0, 32'h80, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
    // fill to full with the pipeline busy; third push held off
    tbl.push_back(v(1, 1, 1, 32'h11, 1, 3, 32'h33,  1, 1, 32'h11, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 32'h12, 1, 4, 32'h44,  1, 1, 32'h12, 0, 32'h08, 1));
    tbl.push_back(v(1, 1, 1, 32'h13, 1, 6, 32'h66,  1, 1, 32'h13, 0, 32'h18, 0));
    tbl.push_back(v(1, 1, 1, 32'h14, 1, 6, 32'h66,  1, 1, 32'h14, 0, 32'h18, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 6, 32'h66,  1, 3, 32'h33, 0, 32'h18, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 6, 32'h66,  1, 4, 32'h44, 0, 32'h10, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  1, 6, 32'h66, 0, 32'h40, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
    // starvation: head denied four cycles, forced out on the fifth
    tbl.push_back(v(1, 1, 1, 32'h100, 1, 9, 32'h99,  1, 1, 32'h100, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 32'h101, 0, 0, 0,  1, 1, 32'h101, 0, 32'h200, 1));
    tbl.push_back(v(1, 1, 1, 32'h102, 0, 0, 0,  1, 1, 32'h102, 0, 32'h200, 1));
    tbl.push_back(v(1, 1, 1, 32'h103, 0, 0, 0,  1, 1, 32'h103, 0, 32'h200, 1));
    tbl.push_back(v(1, 1, 1, 32'h104, 0, 0, 0,  1, 1, 32'h104, 0, 32'h200, 1));
    tbl.push_back(v(1, 1, 1, 32'h105, 0, 0, 0,  1, 9, 32'h99, 1, 32'h200, 1));
    tbl.push_back(v(1, 1, 1, 32'h105, 0, 0, 0,  1, 1, 32'h105, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
    // x0 filtering
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 32'hDEAD,  0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 1, 2, 32'h22,  0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 1, 0, 32'hFF, 0, 0, 0,  1, 2, 32'h22, 0, 32'h04, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
    // two entries sharing rd 5: bit held until both leave
    tbl.push_back(v(1, 1, 1, 32'h1, 1, 5, 32'h51,  1, 1, 32'h1, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 32'h2, 1, 5, 32'h52,  1, 1, 32'h2, 0, 32'h20, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  1, 5, 32'h51, 0, 32'h20, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  1, 5, 32'h52, 0, 32'h20, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));

    rst_n = 1'b0;
    reg_write_w = 1'b0;
    rd_w = '0;
    result_w = '0;
    lu_valid = 1'b0;
    lu_rd = '0;
    lu_data = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // async reset with two entries buffered
    step(v(1, 1, 1, 32'h7, 1, 10, 32'hA0,  1, 1, 32'h7, 0, 0, 1), "ar_fill0");
    step(v(1, 1, 1, 32'h8, 1, 11, 32'hB0,  1, 1, 32'h8, 0, 32'h400, 1), "ar_fill1");
    step(v(1, 1, 1, 32'h9, 0, 0, 0,  1, 1, 32'h9, 0, 32'hC00, 0), "ar_full");
    reg_write_w = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    sb.push_back('{"ar_async", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1});
    compare();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      step(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1), $sformatf("ar_post%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
